// File: rtl/carfield_pll_jtag_idcode_reader_if.sv
// JTAG pin bundle between the IDCODE reader (master) and a TAP (slave).
interface carfield_pll_jtag_idcode_reader_if;
  logic tck;
  logic tms;
  logic tdi;
  logic trst_n;
  logic tdo;

  modport master (output tck, tms, tdi, trst_n, input tdo);
  modport slave  (input tck, tms, tdi, trst_n, output tdo);
endinterface

// File: rtl/carfield_pll_jtag_idcode_reader.sv
// On-chip JTAG master: resets a TAP, walks it to Shift-DR and reads the IDCODE.
// Optional TRST phase before Test-Logic-Reset: define CARFIELD_JTAG_TRST_EN.
module carfield_pll_jtag_idcode_reader #(
  parameter int unsigned          IdLen          = 32,
  parameter logic [IdLen-1:0]     ExpectedIdCode = 32'h1abc0db3,
  parameter int unsigned          TckDiv         = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [IdLen-1:0]     idcode_o,
  output logic                 match_o,
  output logic                 err_o,
  carfield_pll_jtag_idcode_reader_if.master jtag
);

  typedef enum logic [2:0] {IDLE, TRST, TLR, WALK, SHIFT, EXIT} state_e;

  localparam int unsigned     DivW    = (TckDiv > 1) ? $clog2(TckDiv) : 1;
  localparam int unsigned     SlotW   = $clog2(IdLen) + 1;
  localparam logic [DivW-1:0] DivLast = DivW'(TckDiv - 1);
`ifdef CARFIELD_JTAG_TRST_EN
  localparam state_e          FirstSt = TRST;
`else
  localparam state_e          FirstSt = TLR;
`endif

  state_e             state_q, state_d;
  logic               half_q, half_d;
  logic [DivW-1:0]    div_q, div_d;
  logic [SlotW-1:0]   slot_q, slot_d, phase_last;
  logic [IdLen-1:0]   sr_q, idcode_q;
  logic               match_q, err_q, done_q, done_d;
  logic               tck_q, tms_q, tck_d, tms_d;
  logic               accept, sample;

  // a start in the done cycle is dropped so every run produces one clean pulse
  assign accept = (state_q == IDLE) && start_i && !done_q;
  // TDO is stable for the whole high half; take it in the cycle TCK rises
  assign sample = (state_q == SHIFT) && half_q && (div_q == '0);

  always_comb begin
    phase_last = '0;
    case (state_q)
      TRST:    phase_last = SlotW'(3);
      TLR:     phase_last = SlotW'(4);
      WALK:    phase_last = SlotW'(3);
      SHIFT:   phase_last = SlotW'(IdLen - 1);
      EXIT:    phase_last = SlotW'(1);
      default: phase_last = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    div_d   = div_q;
    slot_d  = slot_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (accept) state_d = FirstSt;
    end else if (div_q == DivLast) begin
      div_d  = '0;
      half_d = ~half_q;
      if (half_q) begin
        slot_d = slot_q + SlotW'(1);
        if (slot_q == phase_last) begin
          slot_d = '0;
          case (state_q)
            TRST:    state_d = TLR;
            TLR:     state_d = WALK;
            WALK:    state_d = SHIFT;
            SHIFT:   state_d = EXIT;
            default: begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          endcase
        end
      end
    end else begin
      div_d = div_q + DivW'(1);
    end
  end

  // TMS per slot: WALK = 0,1,0,0; SHIFT leaves on its last bit; EXIT = 1,0
  always_comb begin
    tms_d = 1'b1;
    case (state_d)
      WALK:    tms_d = (slot_d == SlotW'(1));
      SHIFT:   tms_d = (slot_d == SlotW'(IdLen - 1));
      EXIT:    tms_d = (slot_d == '0);
      default: tms_d = 1'b1;
    endcase
    tck_d = (state_d != IDLE) && half_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      half_q   <= 1'b0;
      div_q    <= '0;
      slot_q   <= '0;
      sr_q     <= '0;
      idcode_q <= '0;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      tck_q    <= 1'b0;
      tms_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      div_q   <= div_d;
      slot_q  <= slot_d;
      done_q  <= done_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      if (sample) sr_q <= {jtag.tdo, sr_q[IdLen-1:1]};
      if (accept) begin
        sr_q     <= '0;
        idcode_q <= '0;
        match_q  <= 1'b0;
        err_q    <= 1'b0;
      end else if (done_d) begin
        idcode_q <= sr_q;
        match_q  <= (sr_q == ExpectedIdCode);
        err_q    <= ~sr_q[0] | (&sr_q) | ~(|sr_q);
      end
    end
  end

`ifdef CARFIELD_JTAG_TRST_EN
  logic trst_n_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) trst_n_q <= 1'b1;
    else         trst_n_q <= (state_d != TRST);
  end
  assign jtag.trst_n = trst_n_q;
`else
  assign jtag.trst_n = 1'b1;
`endif

  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;
  assign idcode_o = idcode_q;
  assign match_o  = match_q;
  assign err_o    = err_q;
  assign jtag.tck = tck_q;
  assign jtag.tms = tms_q;
  assign jtag.tdi = 1'b0;

endmodule
